axis_stream_join: RTL and testbench

- Generalised N-input AXI-Stream synchroniser and joiner for the conv-engine input path.
- Joins N_IN independent streams, for example C pixel copies plus one weight stream, into one output beat.
- Each input has its own buffering, so no combinational ready path exists from output to input.
- Adds a runtime stream-enable mask, a registered output, valid-gating of selected tuser bits, tlast-consistency checking and debug counters.

---
 rtl/axis_stream_join.sv | 170 +++++++++++++++++
 tb/tb_axis_stream_join.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_join.sv
// axis_stream_join: N-input AXI-Stream joiner with per-input FIFOs,
// registered output, tuser gating, tlast consistency check and counters.
module axis_stream_join #(
    parameter int                     N_IN      = 3,
    parameter int                     DATA_W    = 64,
    parameter int                     USER_W    = 8,
    parameter int                     DEPTH     = 4,
    parameter logic [USER_W*N_IN-1:0] GATE_MASK = '0,
    parameter int                     LAST_SRC  = N_IN - 1,
    parameter int                     CNT_W     = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [N_IN-1:0]          en_mask,
    input  logic [N_IN-1:0]          s_valid,
    output logic [N_IN-1:0]          s_ready,
    input  logic [N_IN-1:0]          s_last,
    input  logic [N_IN*DATA_W-1:0]   s_data,
    input  logic [N_IN*USER_W-1:0]   s_user,
    input  logic                     m_ready,
    output logic                     m_valid,
    output logic                     m_last,
    output logic [N_IN*DATA_W-1:0]   m_data,
    output logic [N_IN*USER_W-1:0]   m_user,
    output logic                     err_last,
    output logic [CNT_W-1:0]         cnt_beats,
    output logic [CNT_W-1:0]         cnt_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (N_IN < 2 || N_IN > 8) begin : g_bad_n
        $error("axis_stream_join: N_IN must be in 2..8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_stream_join: DEPTH must be a power of 2 and >= 2");
    end
    if (LAST_SRC < 0 || LAST_SRC >= N_IN) begin : g_bad_last
        $error("axis_stream_join: LAST_SRC must be below N_IN");
    end

    logic [N_IN-1:0]        full;
    logic [N_IN-1:0]        empty;
    logic [N_IN-1:0]        push;
    logic [N_IN-1:0]        pop;
    logic [N_IN-1:0]        head_last;
    logic [N_IN*DATA_W-1:0] head_data;
    logic [N_IN*USER_W-1:0] head_user;

    logic all_rdy;
    logic join_fire;
    logic any_last;
    logic all_last;
    logic mismatch;

    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [N_IN*DATA_W-1:0] data_q, data_d;
    logic [N_IN*USER_W-1:0] user_q, user_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       beats_q, beats_d;
    logic [CNT_W-1:0]       errs_q, errs_d;

    // Ready never looks at m_ready; the reset term holds it low for that cycle.
    assign s_ready = en_mask & ~full & {N_IN{~areset}};
    assign push    = s_valid & s_ready;

    for (genvar i = 0; i < N_IN; i++) begin : g_fifo
        logic [DATA_W-1:0] mem_d_q [DEPTH];
        logic [USER_W-1:0] mem_u_q [DEPTH];
        logic [DEPTH-1:0]  mem_l_q;
        logic [AW:0]       wr_q;
        logic [AW:0]       rd_q;

        assign empty[i] = (wr_q == rd_q);
        assign full[i]  = (wr_q[AW] != rd_q[AW]) &&
                          (wr_q[AW-1:0] == rd_q[AW-1:0]);

        assign head_data[i*DATA_W +: DATA_W] =
            en_mask[i] ? mem_d_q[rd_q[AW-1:0]] : '0;
        assign head_user[i*USER_W +: USER_W] =
            en_mask[i] ? mem_u_q[rd_q[AW-1:0]] : '0;
        assign head_last[i] = en_mask[i] & mem_l_q[rd_q[AW-1:0]];

        // Pointer update; reset empties the FIFO.
        always_ff @(posedge aclk) begin
            if (areset) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push[i]) wr_q <= wr_q + 1'b1;
                if (pop[i])  rd_q <= rd_q + 1'b1;
            end
        end

        // Storage write; contents need no reset since pointers gate reads.
        always_ff @(posedge aclk) begin
            if (push[i]) begin
                mem_d_q[wr_q[AW-1:0]] <= s_data[i*DATA_W +: DATA_W];
                mem_u_q[wr_q[AW-1:0]] <= s_user[i*USER_W +: USER_W];
                mem_l_q[wr_q[AW-1:0]] <= s_last[i];
            end
        end
    end

    assign all_rdy   = (&(~en_mask | ~empty)) && (|en_mask);
    assign join_fire = all_rdy && (!valid_q || m_ready);
    assign pop       = en_mask & {N_IN{join_fire}};

    assign any_last = |head_last;
    assign all_last = &(head_last | ~en_mask);
    assign mismatch = any_last && !all_last;

    // Next state of the output register, sticky flag and counters.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        user_d  = user_q;
        err_d   = err_q;
        beats_d = beats_q;
        errs_d  = errs_q;
        if (join_fire) begin
            valid_d = 1'b1;
            last_d  = head_last[LAST_SRC];
            data_d  = head_data;
            user_d  = head_user;
            if (mismatch) begin
                err_d  = 1'b1;
                errs_d = errs_q + 1'b1;
            end
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
        if (valid_q && m_ready) begin
            beats_d = beats_q + 1'b1;
        end
    end

    // Output register and status state.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
            err_q   <= 1'b0;
            beats_q <= '0;
            errs_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            user_q  <= user_d;
            err_q   <= err_d;
            beats_q <= beats_d;
            errs_q  <= errs_d;
        end
    end

    assign m_valid   = valid_q;
    assign m_last    = last_q;
    assign m_data    = data_q;
    assign m_user    = (user_q & ~GATE_MASK) |
                       (user_q & GATE_MASK & {(N_IN*USER_W){valid_q}});
    assign err_last  = err_q;
    assign cnt_beats = beats_q;
    assign cnt_err   = errs_q;

endmodule

// File: tb/tb_axis_stream_join.sv
// tb_axis_stream_join: randomized and directed stimulus with a queue-based
// reference model; a separate monitor scores every output handshake.
module tb_axis_stream_join;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int UW = 8;
    localparam int CW = 32;
    localparam logic [N*UW-1:0] GM = 24'h000001;

    logic            clk = 1'b0;
    logic            areset;
    logic [N-1:0]    en_mask;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [N-1:0]    s_last;
    logic [N*DW-1:0] s_data;
    logic [N*UW-1:0] s_user;
    logic            m_ready;
    logic            m_valid;
    logic            m_last;
    logic [N*DW-1:0] m_data;
    logic [N*UW-1:0] m_user;
    logic            err_last;
    logic [CW-1:0]   cnt_beats;
    logic [CW-1:0]   cnt_err;

    axis_stream_join #(
        .N_IN(N), .DATA_W(DW), .USER_W(UW), .DEPTH(4),
        .GATE_MASK(GM), .LAST_SRC(N-1), .CNT_W(CW)
    ) dut (
        .aclk(clk), .areset(areset), .en_mask(en_mask),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .s_data(s_data), .s_user(s_user), .m_ready(m_ready),
        .m_valid(m_valid), .m_last(m_last), .m_data(m_data),
        .m_user(m_user), .err_last(err_last),
        .cnt_beats(cnt_beats), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [N*DW-1:0] d;
        logic [N*UW-1:0] u;
        logic            l;
    } out_t;

    beat_t        inq [N][$];
    out_t         exp_q [$];
    beat_t        cur [N];
    int           seq [N];
    logic [N-1:0] pend;
    int           total = 0;
    int           bad = 0;
    int           hs = 0;
    int           m_errcnt = 0;
    logic         m_err = 1'b0;
    bit           rnd = 1'b0;
    bit           ovr = 1'b0;
    logic [N-1:0] ovr_last = '0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Zip the per-stream queues: every time all enabled streams hold a
    // beat, their heads form the next expected output beat.
    task automatic model_try();
        bit           ok;
        out_t         o;
        logic [N-1:0] lv;
        beat_t        b;
        while (1) begin
            ok = (en_mask != 0);
            for (int i = 0; i < N; i++)
                if (en_mask[i] && inq[i].size() == 0) ok = 0;
            if (!ok) break;
            o  = '0;
            lv = '0;
            for (int i = 0; i < N; i++) begin
                if (en_mask[i]) begin
                    b = inq[i].pop_front();
                    o.d[i*DW +: DW] = b.d;
                    o.u[i*UW +: UW] = b.u;
                    lv[i] = b.l;
                end
            end
            o.l = lv[N-1];
            if (lv != 0 && lv != en_mask) begin
                m_err = 1'b1;
                m_errcnt++;
            end
            exp_q.push_back(o);
        end
    endtask

    task automatic step(input logic [N-1:0] want, input logic mr,
                        input logic [N-1:0] mask);
        @(negedge clk);
        en_mask = mask;
        m_ready = mr;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && want[i]) begin
                if (rnd) begin
                    cur[i].d = {$urandom, $urandom};
                    cur[i].u = UW'($urandom);
                end else begin
                    cur[i].d = DW'(i * 16 + seq[i]);
                    cur[i].u = UW'(seq[i]);
                end
                cur[i].l = ovr ? ovr_last[i] : (seq[i] % 5 == 4);
                pend[i] = 1'b1;
            end
            s_data[i*DW +: DW] = cur[i].d;
            s_user[i*UW +: UW] = cur[i].u;
            s_last[i]          = cur[i].l;
        end
        s_valid = pend;
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_valid[i] && s_ready[i]) begin
                inq[i].push_back(cur[i]);
                pend[i] = 1'b0;
                seq[i]++;
            end
        end
        model_try();
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset  = 1'b1;
        s_valid = '0;
        pend    = '0;
        m_ready = 1'b1;
        en_mask = '1;
        #1;
        chk("s_ready_in_reset", s_ready, 0);
        for (int i = 0; i < N; i++) begin
            inq[i].delete();
            seq[i] = 0;
        end
        m_err    = 1'b0;
        m_errcnt = 0;
        @(negedge clk);
        areset = 1'b0;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_user", m_user, 0);
        chk("rst_err_last", err_last, 0);
        chk("rst_cnt_beats", cnt_beats, 0);
        chk("rst_cnt_err", cnt_err, 0);
        #1;
        chk("s_ready_after_rst", s_ready, 3'b111);
    endtask

    task automatic drain(input logic [N-1:0] mask);
        for (int c = 0; c < 15; c++) step('0, 1'b1, mask);
        chk("drained", exp_q.size(), 0);
        chk("err_last", err_last, m_err);
        chk("cnt_err", cnt_err, m_errcnt);
    endtask

    task automatic rand_phase(input int n, input logic [N-1:0] mask);
        logic [N-1:0] w;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) w[i] = ($urandom_range(0, 3) != 0);
            step(w, $urandom_range(0, 3) != 0, mask);
        end
    endtask

    // Monitor: scores output handshakes, AXIS hold, tuser gating, cnt_beats.
    initial begin
        out_t prev;
        out_t e;
        bit   hold;
        hold = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            #2;
            if (areset) begin
                exp_q.delete();
                hs   = 0;
                hold = 0;
            end else begin
                chk("cnt_beats", cnt_beats, hs);
                if (!m_valid) chk("user_gate", m_user[0], 0);
                if (hold) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_bus", {m_data, m_user, m_last}, prev);
                end
                if (m_valid && m_ready) begin
                    hs++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got %0h expected none",
                                 m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e.d);
                        chk("m_user", m_user, e.u);
                        chk("m_last", m_last, e.l);
                    end
                end
                hold = m_valid && !m_ready;
                prev = {m_data, m_user, m_last};
            end
        end
    end

    initial begin
        logic [CW-1:0] cb;
        areset  = 1'b1;
        en_mask = '1;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        s_user  = '0;
        m_ready = 1'b1;
        pend    = '0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            cur[i] = '0;
        end
        do_reset();

        for (int c = 0; c <= 102; c++) begin
            step((c < 102) ? 3'b111 : 3'b000, 1'b1, 3'b111);
            if (c == 1)   chk("lat_not_yet", m_valid, 0);
            if (c == 2)   chk("lat_first", m_valid, 1);
            if (c == 102) chk("cnt_100", cnt_beats, 100);
        end
        drain(3'b111);

        for (int c = 0; c < 30; c++) begin
            step((c < 5) ? 3'b011 : 3'b111, 1'b1, 3'b111);
            if (c == 5) begin
                chk("s_ready_full", s_ready[1:0], 0);
                chk("no_join_wo_w", m_valid, 0);
            end
        end
        drain(3'b111);

        cb = '0;
        for (int c = 0; c < 12; c++) begin
            step((c < 6) ? 3'b111 : 3'b000, c >= 10, 3'b111);
            if (c == 10) begin
                cb = cnt_beats;
                chk("held_valid", m_valid, 1);
            end
            if (c == 11) begin
                chk("release_cnt", cnt_beats, cb + 1);
                chk("release_next", m_valid, 1);
            end
        end
        drain(3'b111);

        rnd = 1'b1;
        rand_phase(300, 3'b111);
        drain(3'b111);

        step('0, 1'b1, 3'b101);
        chk("s_ready1_off", s_ready[1], 0);
        rand_phase(200, 3'b101);
        drain(3'b101);
        rand_phase(60, 3'b111);
        drain(3'b111);

        for (int c = 0; c < 5; c++) step('1, 1'b1, 3'b000);
        chk("mask0_ready", s_ready, 0);
        chk("mask0_valid", m_valid, 0);

        do_reset();
        for (int c = 0; c < 3; c++) step(3'b001, 1'b1, 3'b111);
        step('0, 1'b1, 3'b111);
        chk("fifo0_only", m_valid, 0);
        do_reset();
        for (int c = 0; c < 5; c++) step('1, 1'b1, 3'b111);
        drain(3'b111);

        do_reset();
        rnd      = 1'b0;
        ovr      = 1'b1;
        ovr_last = 3'b011;
        step('1, 1'b1, 3'b111);
        ovr = 1'b0;
        step('0, 1'b1, 3'b111);
        chk("err_before", err_last, 0);
        step('0, 1'b1, 3'b111);
        chk("err_set", err_last, 1);
        chk("cnt_err_1", cnt_err, 1);
        chk("m_last_src", m_last, 0);
        for (int c = 0; c < 4; c++) step('1, 1'b1, 3'b111);
        drain(3'b111);
        chk("err_sticky", err_last, 1);
        chk("cnt_err_kept", cnt_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
